// File: rtl/ram_access_arbiter_if.sv
// Request/response bundle between the IF port, the MEM port,
// the data RAM and the arbiter.
interface ram_access_arbiter_if #(
  parameter int ADDR_W = 9
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_rdata;

  logic              mem_req;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic              mem_sedm;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              mem_err;

  logic              ram_en;
  logic              ram_rw;
  logic              ram_sedm;
  logic [1:0]        ram_size;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_rdata,
    input  mem_req, mem_rw, mem_size,
    input  mem_sedm, mem_addr, mem_wdata,
    output mem_ready, mem_rdata, mem_err,
    output ram_en, ram_rw, ram_sedm,
    output ram_size, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_rdata,
    output mem_req, mem_rw, mem_size,
    output mem_sedm, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata, mem_err,
    input  ram_en, ram_rw, ram_sedm,
    input  ram_size, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Two-port (IF / MEM) arbiter for the pulse-enabled 512x8 data RAM.
// Define ARB_ROUND_ROBIN_EN for alternating priority under contention.
module ram_access_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int MEM_BYTES = 512
) (
  input logic                 clk,
  input logic                 reset,
  ram_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE
  } state_t;

  localparam logic [ADDR_W:0] LAST_BYTE =
    (ADDR_W+1)'(MEM_BYTES - 1);

  state_t            state_q, state_d;
  logic              gnt_mem_q, gnt_mem_d;
  logic              err_q, err_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_rw_q, ram_rw_d;
  logic              ram_sedm_q, ram_sedm_d;
  logic [1:0]        ram_size_q, ram_size_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic              if_ready_q, if_ready_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              mem_err_q, mem_err_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_mem_q, last_mem_d;
`endif

  logic              req_if;
  logic              req_mem;
  logic              pick_mem;
  logic [1:0]        mem_span;
  logic              mem_misal;
  logic [ADDR_W:0]   mem_end;
  logic              mem_bad;

  // MEM alignment and range check on the live request fields
  always_comb begin
    mem_span  = 2'd3;
    mem_misal = |bus.mem_addr[1:0];
    unique case (bus.mem_size)
      2'b00: begin
        mem_span  = 2'd0;
        mem_misal = 1'b0;
      end
      2'b01: begin
        mem_span  = 2'd1;
        mem_misal = bus.mem_addr[0];
      end
      default: begin
        mem_span  = 2'd3;
        mem_misal = |bus.mem_addr[1:0];
      end
    endcase
    mem_end = {1'b0, bus.mem_addr}
            + {{(ADDR_W-1){1'b0}}, mem_span};
    mem_bad = mem_misal | (mem_end > LAST_BYTE);
  end

  // Arbitration; a port's req in its own ready cycle is stale
  always_comb begin
    req_if  = bus.if_req & ~if_ready_q;
    req_mem = bus.mem_req & ~mem_ready_q;
`ifdef ARB_ROUND_ROBIN_EN
    pick_mem = req_mem & (~req_if | ~last_mem_q);
`else
    pick_mem = req_mem;
`endif
  end

  // Access sequencer: next state, RAM strobe train, responses
  always_comb begin
    state_d     = state_q;
    gnt_mem_d   = gnt_mem_q;
    err_d       = err_q;
    ram_en_d    = 1'b0;
    ram_rw_d    = ram_rw_q;
    ram_sedm_d  = ram_sedm_q;
    ram_size_d  = ram_size_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    if_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_err_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_mem_d  = last_mem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_if | req_mem) begin
          gnt_mem_d = pick_mem;
`ifdef ARB_ROUND_ROBIN_EN
          last_mem_d = pick_mem;
`endif
          if (pick_mem) begin
            ram_rw_d   = bus.mem_rw;
            ram_sedm_d = bus.mem_sedm;
            ram_size_d = bus.mem_size;
            ram_addr_d = bus.mem_addr;
            ram_din_d  = bus.mem_wdata;
            err_d      = mem_bad;
            state_d    = mem_bad ? S_CAPTURE
                                 : S_SETUP;
          end else begin
            ram_rw_d   = 1'b0;
            ram_sedm_d = 1'b0;
            ram_size_d = 2'b10;
            ram_addr_d = bus.if_addr & ~ADDR_W'(3);
            err_d      = 1'b0;
            state_d    = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        ram_en_d = 1'b1;
        state_d  = S_STROBE;
      end
      S_STROBE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        if (gnt_mem_q) begin
          mem_ready_d = 1'b1;
          mem_err_d   = err_q;
          if (!err_q && !ram_rw_q)
            mem_rdata_d = bus.ram_dout;
        end else begin
          if_ready_d = 1'b1;
          if_rdata_d = bus.ram_dout;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gnt_mem_q   <= 1'b0;
      err_q       <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_sedm_q  <= 1'b0;
      ram_size_q  <= 2'b00;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      mem_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_mem_q   <= gnt_mem_d;
      err_q       <= err_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_sedm_q  <= ram_sedm_d;
      ram_size_q  <= ram_size_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      mem_err_q   <= mem_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_rw    = ram_rw_q;
  assign bus.ram_sedm  = ram_sedm_q;
  assign bus.ram_size  = ram_size_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_err   = mem_err_q;

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single byte-addressed 512x8 data RAM (pulse-enabled, write/read on the rising edge of its Enable) between two requesters: the instruction-fetch (IF) port and the load/store (MEM) port of the RISC-V pipeline.
- Sequences each access as a setup / strobe / capture pulse train.
- Latches the requester's command at grant and returns read data with a one-cycle ready pulse.
- Flags misaligned or out-of-range accesses without touching the RAM.

Parameters:
- ADDR_W, 9, RAM byte-address width.
- MEM_BYTES, 512, RAM size in bytes; used for the range check.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- if_req  input  1  IF word-read request; held until if_ready
- if_addr  input  ADDR_W  IF byte address
- if_ready  output  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  output  32  fetched word
- mem_req  input  1  MEM request; held until mem_ready
- mem_rw  input  1  1 = write, 0 = read
- mem_size  input  2  00 = byte, 01 = halfword, 10 = word (11 is treated as word)
- mem_sedm  input  1  sign-extend load data
- mem_addr  input  ADDR_W  MEM byte address
- mem_wdata  input  32  store data
- mem_ready  output  1  one-cycle completion pulse
- mem_rdata  output  32  load data; valid with mem_ready when mem_rw=0
- mem_err  output  1  pulses with mem_ready when the access was rejected
- ram_en  output  1  RAM Enable strobe
- ram_rw  output  1  RAM ReadWrite
- ram_sedm  output  1  RAM SEDM
- ram_size  output  2  RAM Size
- ram_addr  output  ADDR_W  RAM Address
- ram_din  output  32  RAM DataIn
- ram_dout  input  32  RAM DataOut

Behaviour:
- Reset values: all outputs are 0. The FSM returns to IDLE and the grant register clears.
- Reset mid-access: ram_en drops at the next edge and no ready pulse is produced. A write whose strobe has already risen stays committed.
- FSM states: IDLE, SETUP, STROBE, CAPTURE.
- IDLE:
  - If any request is pending, arbitrate and latch the winner's fields into the ram_* registers. The IF port is latched as rw=0, size=10, sedm=0.
  - Go to SETUP with ram_en=0.
- Range/alignment check at grant (MEM only):
  - halfword requires addr[0]=0; word requires addr[1:0]=00.
  - addr+bytes-1 must be ≤ MEM_BYTES-1.
  - On failure: go directly to CAPTURE with ram_en never asserted, pulse mem_ready and mem_err, and leave mem_rdata unchanged.
- IF check: if_addr[1:0] != 00 is forced aligned by clearing the two LSBs. No error output exists on the IF port.
- SETUP: ram_* held stable, ram_en=0. This guarantees address/data setup before the strobe edge.
- STROBE: ram_en=1 for exactly one cycle.
- CAPTURE:
  - ram_en=0.
  - On a read, load ram_dout into the winner's rdata register.
  - Pulse the winner's ready, then return to IDLE.
- Latency: request seen in IDLE at edge N gives ready high in the cycle after edge N+3. This is 4 cycles per access, with a minimum 1 IDLE cycle between accesses.
- Ready and rdata behaviour:
  - Ready is high for exactly one cycle.
  - rdata holds its value until the next completed read on the same port.
- Arbitration (default): MEM has fixed priority over IF, which avoids stalling the load/store stage.
- Requester inputs are sampled only at grant. Changes after grant are ignored. Dropping req before grant cancels that request.
- req still high in the cycle after ready is treated as a new request.
- ram_din is driven with mem_wdata unmodified; the RAM performs the byte/half selection.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant register (reset to IF) gives priority to the port not granted last when both request in IDLE.
  - A single requester always wins immediately.
- Undefined: fixed MEM-over-IF priority, and the last-grant register is absent.

Test Plan:
- Store then load, single port:
  - Stimulus: MEM write word 0xDEADBEEF at 0x010, then read word at 0x010.
  - Response: ram_en pulses once per access; mem_ready arrives 4 cycles after each grant; mem_rdata=0xDEADBEEF; mem_err=0.
- Sign extension:
  - Stimulus: write byte 0x80 at 0x021; read byte at 0x021 with sedm=1, then with sedm=0.
  - Response: mem_rdata=0xFFFFFF80, then 0x00000080.
- Contention:
  - Stimulus: if_req and mem_req asserted in the same cycle.
  - Without macro: MEM completes first and IF completes 4 cycles later.
  - With ARB_ROUND_ROBIN_EN and a prior MEM grant: IF is served first.
- Misaligned and range errors:
  - Stimulus 1: MEM word read at 0x102. Response: mem_ready and mem_err pulse with no ram_en pulse; mem_rdata unchanged.
  - Stimulus 2: word at 0x1FE. Response: same error behaviour.
  - Stimulus 3: halfword at 0x1FE. Response: succeeds.
- Reset mid-access:
  - Stimulus: assert reset during STROBE of a MEM read.
  - Response: next cycle ram_en=0 and all outputs are 0; no mem_ready pulse; the next request after reset completes normally.
- Request held:
  - Stimulus: if_req held high for 12 cycles at 0x000, with no MEM traffic.
  - Response: if_ready pulses every 5 cycles (4 access + 1 IDLE), 3 completions in total.
